// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio output stage.
package audio_pkg;

   localparam int unsigned FRAME_BITS = 64;
   localparam int unsigned SLOT_BITS  = 32;
   localparam int unsigned DATA_BITS  = 16;

   typedef enum logic {IDLE, RUN} i2s_state_t;

   typedef logic signed [15:0] pcm16_t;

endpackage

// File: rtl/i2s_audio_out_if.sv
// Sample hand-off between the synth mixer (master) and the I2S output stage (slave).
interface i2s_audio_out_if;

   logic               SAMPLE_VALID;
   logic signed [31:0] SAMPLE_IN;
   logic               SAMPLE_REQ;

   modport master (
      output SAMPLE_VALID,
      output SAMPLE_IN,
      input  SAMPLE_REQ
   );

   modport slave (
      input  SAMPLE_VALID,
      input  SAMPLE_IN,
      output SAMPLE_REQ
   );

endinterface

// File: rtl/audio_sat.sv
// Arithmetic shift and narrowing of the 32-bit mix to a 16-bit PCM word.
// AUDIO_SAT_EN selects saturation with clip detect; otherwise the word wraps.
module audio_sat
   import audio_pkg::*;
#(
   parameter int unsigned SHIFT = 15
) (
   input  logic signed [31:0] din,
   output pcm16_t             dout,
   output logic               clip
);

   logic signed [31:0] t;

   assign t = din >>> SHIFT;

`ifdef AUDIO_SAT_EN
   always_comb begin
      dout = t[15:0];
      clip = 1'b0;
      if (t > 32'sd32767) begin
         dout = 16'sh7FFF;
         clip = 1'b1;
      end else if (t < -32'sd32768) begin
         dout = 16'sh8000;
         clip = 1'b1;
      end
   end
`else
   logic unused_hi;

   assign dout      = t[15:0];
   assign clip      = 1'b0;
   assign unused_hi = ^t[31:16];
`endif

endmodule

// File: rtl/i2s_audio_out.sv
// Mono (L=R) 16-bit I2S serializer with one-deep sample buffer and sticky status flags.
// Optional AUDIO_SAT_EN build saturates the conversion and reports CLIP.
module i2s_audio_out
   import audio_pkg::*;
#(
   parameter int unsigned CLK_DIV = 8,
   parameter int unsigned SHIFT   = 15
) (
   input  logic            CLK,
   input  logic            RESET,
   i2s_audio_out_if.slave  mix,
   input  logic            CLR_FLAGS,
   output logic            AUD_BCLK,
   output logic            AUD_DACLRCK,
   output logic            AUD_DACDAT,
   output logic            UNDERRUN,
   output logic            OVERRUN,
   output logic            CLIP
);

   localparam int unsigned DIV_W  = $clog2(CLK_DIV);
   localparam int unsigned BIT_W  = $clog2(FRAME_BITS);
   localparam int unsigned SLOT_W = $clog2(SLOT_BITS);
   localparam int unsigned DATA_W = $clog2(DATA_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

   i2s_state_t       state_q;
   logic             boot_q;
   logic [DIV_W-1:0] div_q;
   logic             bclk_q;
   logic [BIT_W-1:0] bit_q;
   logic             lrck_q;
   logic             dat_q;
   logic             req_q;
   pcm16_t           shreg_q;
   pcm16_t           pend_q;
   logic             pend_vld_q;
   logic             underrun_q;
   logic             overrun_q;
   logic             clip_q;

   pcm16_t            conv;
   logic              conv_clip;
   logic              div_wrap;
   logic              bclk_fall;
   logic              frame_load;
   logic [BIT_W-1:0]  bit_nx;
   logic [SLOT_W-1:0] slot_nx;
   logic [DATA_W-1:0] data_idx;
   logic              slot_bit;

   // One converter serves both the pending-capture and the bypass path.
   audio_sat #(
      .SHIFT (SHIFT)
   ) u_sat (
      .din  (mix.SAMPLE_IN),
      .dout (conv),
      .clip (conv_clip)
   );

   always_comb begin
      div_wrap   = (div_q == DIV_LAST);
      bclk_fall  = (state_q == RUN) && div_wrap && bclk_q;
      frame_load = bclk_fall && (bit_q == BIT_LAST);
      bit_nx     = bit_q + BIT_W'(1);
      slot_nx    = bit_nx[SLOT_W-1:0];
      data_idx   = DATA_W'(SLOT_W'(DATA_BITS) - slot_nx);
      slot_bit   = 1'b0;
      // Slot 0 is the I2S one-bit delay; bits past the word are padding.
      if ((slot_nx != '0) && (slot_nx <= SLOT_W'(DATA_BITS))) begin
         slot_bit = shreg_q[data_idx];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         boot_q     <= 1'b1;
         div_q      <= '0;
         bclk_q     <= 1'b0;
         bit_q      <= '0;
         lrck_q     <= 1'b0;
         dat_q      <= 1'b0;
         req_q      <= 1'b0;
         shreg_q    <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
         clip_q     <= 1'b0;
      end else begin
         req_q <= 1'b0;
         if (CLR_FLAGS) begin
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            clip_q     <= 1'b0;
         end
         if (mix.SAMPLE_VALID && conv_clip) begin
            clip_q <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (boot_q) begin
                  req_q  <= 1'b1;
                  boot_q <= 1'b0;
               end
               if (mix.SAMPLE_VALID) begin
                  shreg_q <= conv;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (div_wrap) begin
                  div_q  <= '0;
                  bclk_q <= ~bclk_q;
               end else begin
                  div_q <= div_q + DIV_W'(1);
               end
               if (bclk_fall) begin
                  bit_q  <= bit_nx;
                  lrck_q <= bit_nx[BIT_W-1];
                  dat_q  <= slot_bit;
               end
               if (frame_load) begin
                  req_q <= 1'b1;
                  if (mix.SAMPLE_VALID) begin
                     // Newest sample wins; an unconsumed pending word is dropped.
                     shreg_q    <= conv;
                     pend_vld_q <= 1'b0;
                     if (pend_vld_q) begin
                        overrun_q <= 1'b1;
                     end
                  end else if (pend_vld_q) begin
                     shreg_q    <= pend_q;
                     pend_vld_q <= 1'b0;
                  end else begin
                     underrun_q <= 1'b1;
                  end
               end else if (mix.SAMPLE_VALID) begin
                  pend_q     <= conv;
                  pend_vld_q <= 1'b1;
                  if (pend_vld_q) begin
                     overrun_q <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign mix.SAMPLE_REQ = req_q;
   assign AUD_BCLK       = bclk_q;
   assign AUD_DACLRCK    = lrck_q;
   assign AUD_DACDAT     = dat_q;
   assign UNDERRUN       = underrun_q;
   assign OVERRUN        = overrun_q;
   assign CLIP           = clip_q;

endmodule
